// File: rtl/wptr_flag_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO.
// Keeps the binary and Gray write pointers and brings the read-side Gray
// pointer into this clock domain through a SYNC_STAGES-deep flop chain.
// From these it produces full, almost_full and free_cnt as registered flags.
// Optional macro WPTR_OVF_ERR_EN adds a sticky overflow error flag
// (ovf_err) with its clear input (ovf_clr).
module wptr_flag_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  w_rst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   Gray_rptr,
`ifdef WPTR_OVF_ERR_EN
  input  logic                  ovf_clr,
  output logic                  ovf_err,
`endif
  output logic                  w_ack,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   binary_wptr,
  output logic [ADDR_WIDTH:0]   gray_wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   free_cnt
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(1 << ADDR_WIDTH);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] rptr_bin;

  logic [PW-1:0] bin_q;
  logic [PW-1:0] gray_q;
  logic          full_q;
  logic          af_q;
  logic [PW-1:0] free_q;

  logic [PW-1:0] wptr_nxt;
  logic [PW-1:0] used_nxt;
  logic [PW-1:0] free_d;
  logic          full_d;
  logic          af_d;

  // Read-pointer synchronizer chain; stage 0 samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= Gray_rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rptr_sync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
      assign rptr_bin[gi] = ^rptr_sync[PW-1:gi];
    end
  endgenerate

  // A write is accepted only when there is room and reset is not active.
  assign w_ack = w_en & ~full_q & ~w_rst;

  // Next pointer and flags; flags look ahead to the post-write pointer so
  // the write that takes the last slot raises full on the same edge.
  always_comb begin
    wptr_nxt = bin_q + {{ADDR_WIDTH{1'b0}}, w_ack};
    used_nxt = wptr_nxt - rptr_bin;
    free_d   = DEPTH_W - used_nxt;
    full_d   = (used_nxt == DEPTH_W);
    af_d     = (free_d <= af_thresh);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      af_q   <= (DEPTH_W <= af_thresh);
      free_q <= DEPTH_W;
    end else begin
      bin_q  <= wptr_nxt;
      gray_q <= wptr_nxt ^ (wptr_nxt >> 1);
      full_q <= full_d;
      af_q   <= af_d;
      free_q <= free_d;
    end
  end

`ifdef WPTR_OVF_ERR_EN
  logic ovf_q;

  // Sticky overflow flag: a dropped request sets it and beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      ovf_q <= 1'b0;
    end else if (w_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_err = ovf_q;
`endif

  assign w_addr      = bin_q[ADDR_WIDTH-1:0];
  assign binary_wptr = bin_q;
  assign gray_wptr   = gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign free_cnt    = free_q;

endmodule

// File: tb/tb_wptr_flag_ctrl.sv
// Directed bench for wptr_flag_ctrl with ADDR_WIDTH=4, SYNC_STAGES=2.
module tb_wptr_flag_ctrl;

  localparam int AW = 4;

  logic          clk;
  logic          w_rst;
  logic          w_en;
  logic [AW:0]   af_thresh;
  logic [AW:0]   Gray_rptr;
  logic          w_ack;
  logic [AW-1:0] w_addr;
  logic [AW:0]   binary_wptr;
  logic [AW:0]   gray_wptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   free_cnt;
`ifdef WPTR_OVF_ERR_EN
  logic          ovf_clr;
  logic          ovf_err;
`endif

  int total;
  int bad;

  wptr_flag_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .w_rst(w_rst),
    .w_en(w_en),
    .af_thresh(af_thresh),
    .Gray_rptr(Gray_rptr),
`ifdef WPTR_OVF_ERR_EN
    .ovf_clr(ovf_clr),
    .ovf_err(ovf_err),
`endif
    .w_ack(w_ack),
    .w_addr(w_addr),
    .binary_wptr(binary_wptr),
    .gray_wptr(gray_wptr),
    .full(full),
    .almost_full(almost_full),
    .free_cnt(free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    w_rst = 1'b1; w_en = 1'b1; Gray_rptr = '0; af_thresh = 5'd16;
    #1;
    total++;
    if (w_ack !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b exp=0", w_ack); end
    tick();
    total++;
    if (almost_full !== 1'b1) begin bad++; $display("FAIL rst_af_thr16 got=%b exp=1", almost_full); end
    af_thresh = 5'd3;
    #1;
    total++;
    if (w_ack !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b exp=0", w_ack); end
    tick();
    w_rst = 1'b0; w_en = 1'b0;
    $display("reset: wptr=%0d gray=%h full=%b af=%b free=%0d", binary_wptr, gray_wptr, full, almost_full, free_cnt);
    total++;
    if (binary_wptr !== 5'd0) begin bad++; $display("FAIL rst_wptr got=%0d exp=0", binary_wptr); end
    total++;
    if (gray_wptr !== 5'd0) begin bad++; $display("FAIL rst_gray got=%h exp=0", gray_wptr); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
    total++;
    if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almost_full); end
    total++;
    if (free_cnt !== 5'd16) begin bad++; $display("FAIL rst_free got=%0d exp=16", free_cnt); end
`ifdef WPTR_OVF_ERR_EN
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf_err); end
`endif
  endtask

  task automatic test_fill();
    logic [AW:0] k5;
    logic [AW:0] g_exp;
    logic [AW:0] f_exp;
    for (int k = 1; k <= 16; k++) begin
      k5 = AW'(0) + 5'(k);
      g_exp = k5 ^ (k5 >> 1);
      f_exp = 5'(16 - k);
      w_en = 1'b1;
      #1;
      total++;
      if (w_ack !== 1'b1) begin bad++; $display("FAIL fill_ack k=%0d got=%b exp=1", k, w_ack); end
      total++;
      if (w_addr !== 4'(k - 1)) begin bad++; $display("FAIL fill_addr k=%0d got=%0d exp=%0d", k, w_addr, k - 1); end
      tick();
      $display("fill %0d: wptr=%0d gray=%h full=%b af=%b free=%0d", k, binary_wptr, gray_wptr, full, almost_full, free_cnt);
      total++;
      if (binary_wptr !== k5) begin bad++; $display("FAIL fill_wptr k=%0d got=%0d exp=%0d", k, binary_wptr, k5); end
      total++;
      if (gray_wptr !== g_exp) begin bad++; $display("FAIL fill_gray k=%0d got=%h exp=%h", k, gray_wptr, g_exp); end
      total++;
      if (free_cnt !== f_exp) begin bad++; $display("FAIL fill_free k=%0d got=%0d exp=%0d", k, free_cnt, f_exp); end
      total++;
      if (full !== (k == 16)) begin bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, full, (k == 16)); end
      total++;
      if (almost_full !== (f_exp <= 5'd3)) begin bad++; $display("FAIL fill_af k=%0d got=%b exp=%b", k, almost_full, (f_exp <= 5'd3)); end
    end
    total++;
    if (gray_wptr !== 5'h18) begin bad++; $display("FAIL fill_gray16 got=%h exp=18", gray_wptr); end
    // 17th request hits a full FIFO and must be dropped.
    w_en = 1'b1;
    #1;
    total++;
    if (w_ack !== 1'b0) begin bad++; $display("FAIL drop_ack got=%b exp=0", w_ack); end
    tick();
    w_en = 1'b0;
    $display("drop: wptr=%0d full=%b", binary_wptr, full);
    total++;
    if (binary_wptr !== 5'd16) begin bad++; $display("FAIL drop_wptr got=%0d exp=16", binary_wptr); end
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL drop_full got=%b exp=1", full); end
  endtask

`ifdef WPTR_OVF_ERR_EN
  task automatic test_ovf();
    ovf_clr = 1'b0;
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    tick();
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%b exp=1", ovf_err); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_err); end
    w_en = 1'b1; ovf_clr = 1'b1;
    tick();
    w_en = 1'b0; ovf_clr = 1'b0;
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_setwins got=%b exp=1", ovf_err); end
    tick();
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_hold2 got=%b exp=1", ovf_err); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("ovf: ovf_err=%b", ovf_err);
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr2 got=%b exp=0", ovf_err); end
  endtask
`endif

  task automatic test_drain();
    w_en = 1'b0;
    Gray_rptr = 5'h06;
    tick();
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL drain_e1 got=%b exp=1", full); end
    tick();
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL drain_e2 got=%b exp=1", full); end
    tick();
    $display("drain: full=%b free=%0d af=%b", full, free_cnt, almost_full);
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL drain_e3 got=%b exp=0", full); end
    total++;
    if (free_cnt !== 5'd4) begin bad++; $display("FAIL drain_free got=%0d exp=4", free_cnt); end
    total++;
    if (almost_full !== 1'b0) begin bad++; $display("FAIL drain_af got=%b exp=0", almost_full); end
  endtask

  task automatic test_wrap();
    logic [AW:0] wp;
    Gray_rptr = 5'h18;
    tick(); tick(); tick();
    total++;
    if (free_cnt !== 5'd16) begin bad++; $display("FAIL wrap_empty got=%0d exp=16", free_cnt); end
    for (int k = 1; k <= 16; k++) begin
      w_en = 1'b1;
      #1;
      total++;
      if (w_ack !== 1'b1) begin bad++; $display("FAIL wrap_ack k=%0d got=%b exp=1", k, w_ack); end
      tick();
      wp = 5'((16 + k) % 32);
      $display("wrap %0d: wptr=%0d gray=%h full=%b", k, binary_wptr, gray_wptr, full);
      total++;
      if (binary_wptr !== wp) begin bad++; $display("FAIL wrap_wptr k=%0d got=%0d exp=%0d", k, binary_wptr, wp); end
      total++;
      if (full !== (k == 16)) begin bad++; $display("FAIL wrap_full k=%0d got=%b exp=%b", k, full, (k == 16)); end
      if (k == 15) begin
        total++;
        if (gray_wptr !== 5'h10) begin bad++; $display("FAIL wrap_gray31 got=%h exp=10", gray_wptr); end
      end
      if (k == 16) begin
        total++;
        if (gray_wptr !== 5'h00) begin bad++; $display("FAIL wrap_gray0 got=%h exp=00", gray_wptr); end
      end
    end
    w_en = 1'b0;
  endtask

  task automatic test_midreset();
    Gray_rptr = 5'h00;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      w_en = 1'b1;
      tick();
    end
    total++;
    if (binary_wptr !== 5'd3) begin bad++; $display("FAIL mid_pre got=%0d exp=3", binary_wptr); end
    w_rst = 1'b1;
    #1;
    total++;
    if (w_ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0", w_ack); end
    tick();
    w_rst = 1'b0; w_en = 1'b0;
    $display("midreset: wptr=%0d free=%0d full=%b", binary_wptr, free_cnt, full);
    total++;
    if (binary_wptr !== 5'd0) begin bad++; $display("FAIL mid_wptr got=%0d exp=0", binary_wptr); end
    total++;
    if (free_cnt !== 5'd16) begin bad++; $display("FAIL mid_free got=%0d exp=16", free_cnt); end
  endtask

  task automatic test_back_to_back();
    w_en = 1'b1;
    tick(); tick();
    w_en = 1'b0;
    total++;
    if (free_cnt !== 5'd14) begin bad++; $display("FAIL b2b_pre got=%0d exp=14", free_cnt); end
    Gray_rptr = 5'h01;
    tick();
    tick();
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
    $display("simul: wptr=%0d free=%0d", binary_wptr, free_cnt);
    total++;
    if (binary_wptr !== 5'd3) begin bad++; $display("FAIL b2b_wptr got=%0d exp=3", binary_wptr); end
    total++;
    if (free_cnt !== 5'd14) begin bad++; $display("FAIL b2b_free got=%0d exp=14", free_cnt); end
    tick();
    total++;
    if (free_cnt !== 5'd14) begin bad++; $display("FAIL b2b_after got=%0d exp=14", free_cnt); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    w_rst = 1'b1;
    w_en = 1'b0;
    af_thresh = 5'd3;
    Gray_rptr = '0;
`ifdef WPTR_OVF_ERR_EN
    ovf_clr = 1'b0;
`endif
    test_reset();
    test_fill();
`ifdef WPTR_OVF_ERR_EN
    test_ovf();
`endif
    test_drain();
    test_wrap();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wptr_flag_ctrl.md
Name: wptr_flag_ctrl

Overview:
Write-domain pointer and flag controller for the dual-clock FIFO. This is the parametrised successor of the basic producer pointer block. It holds the binary and Gray write pointers and brings the read-side Gray pointer into the write domain through an internal N-stage synchronizer. From these it computes full, almost-full and free-space count, and it acknowledges each accepted write. It feeds the FIFO RAM write address and exports the Gray write pointer to the consumer-side controller.

Parameters:
ADDR_WIDTH, 9, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, flop stages on the incoming read Gray pointer; legal range 2..4.

Ports:
clk  in  1  write-domain clock.
w_rst  in  1  synchronous, active-high reset.
w_en  in  1  write request for this cycle.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold, in free words; quasi-static.
Gray_rptr  in  ADDR_WIDTH+1  read pointer in Gray code, from the read domain, unsynchronised.
w_ack  out  1  write accepted this cycle; combinational.
w_addr  out  ADDR_WIDTH  RAM write address, equal to binary_wptr[ADDR_WIDTH-1:0].
binary_wptr  out  ADDR_WIDTH+1  registered binary write pointer.
gray_wptr  out  ADDR_WIDTH+1  registered Gray write pointer.
full  out  1  registered.
almost_full  out  1  registered.
free_cnt  out  ADDR_WIDTH+1  registered free-word count, range 0..DEPTH.

Behaviour:
- Reset, applied on the first clk edge with w_rst=1:
  - binary_wptr=0, gray_wptr=0, all synchronizer flops=0.
  - full=0, free_cnt=DEPTH.
  - almost_full=(DEPTH<=af_thresh).
  - Reset asserted mid-operation discards all state on that edge. w_ack=0 while w_rst=1.
- Synchronizer: Gray_rptr passes through SYNC_STAGES flops to give rptr_sync. The last stage is converted Gray-to-binary to give rptr_bin, using an XOR-prefix from the MSB down.
- Handshake: w_ack = w_en & ~full & ~w_rst.
  - A request while full is dropped: pointer unchanged, no RAM write.
  - w_addr is valid in the cycle w_ack=1; the RAM writes at that edge.
- Next pointer: wptr_nxt = binary_wptr + w_ack, modulo 2**(ADDR_WIDTH+1), so it wraps from all-ones to 0.
- Gray encoding: gray_wptr <= wptr_nxt ^ (wptr_nxt>>1), registered. It changes by exactly one bit per accepted write.
- Flags, all registered and computed from wptr_nxt and the current rptr_bin:
  - used_nxt = (wptr_nxt - rptr_bin) mod 2**(ADDR_WIDTH+1).
  - free_cnt <= DEPTH - used_nxt.
  - full <= (used_nxt == DEPTH), i.e. MSBs differ and lower bits are equal.
  - almost_full <= (DEPTH - used_nxt) <= af_thresh. With af_thresh=0, almost_full equals full.
- Latency:
  - A write sets full on the same edge that consumes the last free slot, so no overrun is possible.
  - A read-pointer change reaches full, almost_full and free_cnt SYNC_STAGES+1 clk edges after it is stable at Gray_rptr. This is conservative: full may stay asserted longer than necessary, but is never deasserted early.
- Simultaneous write and read-pointer advance: both terms apply in the same update, so free_cnt stays unchanged.

Optional Feature:
Macro: WPTR_OVF_ERR_EN.
- Defined:
  - Adds port ovf_clr (in, 1) and port ovf_err (out, 1, registered).
  - ovf_err is set on the edge after a cycle with w_en=1 and full=1. It stays set until the first edge with ovf_clr=1 or w_rst=1.
  - If a set and a clear occur in the same cycle, the set wins.
- Undefined: neither port exists, and dropped writes are silent.

Test Plan:
- Reset (ADDR_WIDTH=4, af_thresh=3): hold w_rst=1 for 2 cycles, then release -> binary_wptr=0, gray_wptr=0, full=0, almost_full=0, free_cnt=16, w_ack=0 during reset.
- Fill (ADDR_WIDTH=4, Gray_rptr=0): w_en=1 for 17 cycles -> w_ack=1 on the first 16 cycles. After the 16th edge: binary_wptr=16, gray_wptr=0x18, full=1, free_cnt=0. The 17th cycle gives w_ack=0 and the pointer stays unchanged.
- Almost-full threshold (af_thresh=3): after 12 writes -> almost_full=0, free_cnt=4. After 13 writes -> almost_full=1, free_cnt=3.
- Drain latency (full FIFO, SYNC_STAGES=2): set Gray_rptr=0x6 (binary 4) -> full stays 1 for exactly 2 edges and clears on the 3rd edge, with free_cnt=4 and almost_full=0.
- Wrap-around: with Gray_rptr=0x18 (binary 16), write 16 words from wptr=16 -> wptr passes 31 (gray 0x10) to 0 (gray 0x00), and full=1 at wptr=0.
- WPTR_OVF_ERR_EN: write once while full -> ovf_err=1 on the next edge and stays set. Pulse ovf_clr -> ovf_err=0. Pulse ovf_clr in the same cycle as an overflow write -> ovf_err stays 1.
